ub_input_feeder: RTL
====================

// Module: ub_input_feeder
// PURPOSE
// Reads one 2x2 activation tile (4 words) from unified_buffer through its addr/load_input read port.
// Streams the tile into the 2-row systolic array as two skewed lanes (row 2 lags row 1 by one cycle).
// Sits between unified_buffer's out_ub_00..11 outputs and the array's left-edge activation inputs.
// PARAMETERS
// DATA_W    32  activation word width
// ADDR_W    13  unified-buffer address width
// UB_DEPTH  64  unified-buffer word count; legal tile base is 0..UB_DEPTH-4
// LOAD_LAT  1   cycles from load_input sampled to out_ub_* valid (>=1)
// PORTS
// clk            in   1       clock
// reset          in   1       synchronous, active-low reset
// start          in   1       request tile fetch+feed; sampled only in IDLE
// base_addr      in   ADDR_W  tile base address; latched when start accepted
// array_ready    in   1       array can accept a lane beat this cycle
// ub_addr        out  ADDR_W  read address to unified_buffer
// ub_load_input  out  1       read strobe to unified_buffer (1-cycle pulse)
// ub_in_00..11   in   DATA_W  tile words from unified_buffer (row-major)
// lane1_data     out  DATA_W  activation to array row 1
// lane1_valid    out  1       lane1_data valid
// lane2_data     out  DATA_W  activation to array row 2
// lane2_valid    out  1       lane2_data valid
// busy           out  1       high in every state except IDLE
// done           out  1       1-cycle pulse: tile fully fed or rejected
// addr_err       out  1       1-cycle pulse with done when base_addr > UB_DEPTH-4
// BEHAVIOUR
// - Reset (reset==0 at edge): state IDLE; all outputs 0; tile regs 0; wait counter 0. Reset mid-op aborts, no done.
// - FSM: IDLE -> REQ -> WAIT -> FEED0 -> FEED1 -> FEED2 -> DONE -> IDLE.
// - IDLE: start==1 latches base_addr. If base_addr > UB_DEPTH-4 -> DONE with addr_err. Else -> REQ.
// - REQ (1 cycle): ub_load_input=1, ub_addr=latched base. Otherwise ub_load_input=0, ub_addr holds last value.
// - WAIT: LOAD_LAT cycles. On its last edge capture ub_in_00..11 into tile regs t00,t01,t10,t11 -> FEED0.
// - FEED0: lane1=t00/valid; lane2=0/invalid.
// - FEED1: lane1=t01/valid; lane2=t10/valid.
// - FEED2: lane1=0/invalid; lane2=t11/valid.
// - FEEDk advances on an edge only if array_ready==1. If array_ready==0, hold the same lane data/valid (no beat lost or repeated).
// - Lane outputs are 0 whenever their valid is 0. Values are pass-through, no arithmetic.
// - DONE (1 cycle): done=1, busy=1, lanes idle; -> IDLE. start during any non-IDLE state is ignored (not queued).
// - Nominal latency (LOAD_LAT=1, array_ready=1): start sampled at edge 0.
//   REQ cycle 1, WAIT cycle 2, FEED0..2 cycles 3..5, done cycle 6, IDLE cycle 7.
// - array_ready is ignored outside FEED states. A tile change in unified_buffer after capture does not affect the feed.
// - Simultaneous reset and start: reset wins.
// STRUCTURE
// - Shared package tpu_pkg: DATA_W, ADDR_W, UB_DEPTH constants; feeder_state_t enum (IDLE,REQ,WAIT,FEED0,FEED1,FEED2,DONE).
// - Single module: FSM, wait counter, tile capture registers, lane output mux.
// - Natural sub-module: skew_lane_reg (one-stage DATA_W+valid register with hold enable) drives lane2.
// TESTING
// - Basic: UB holds 11,12,21,22 at 0x1E..0x21; start, base_addr=0x1E, array_ready=1.
//   -> ub_load_input pulse at cycle 1, addr 0x1E; lane1 11,12,- / lane2 -,21,22 on cycles 3..5; done at cycle 6.
// - Stall: same tile, array_ready=0 during cycle 4.
//   -> lane1=12, lane2=21 held for cycles 4-5; lane2=22 at cycle 6; done at cycle 7.
// - Bad address: base_addr=61 (UB_DEPTH=64).
//   -> no ub_load_input; done=1 and addr_err=1 in cycle 1; busy=0 in cycle 2.
// - Ignored start: pulse start with base_addr=0 during FEED1.
//   -> current tile completes unchanged; exactly one done; no second ub_load_input.
// - Reset mid-feed: reset=0 during FEED1.
//   -> next cycle all outputs 0, busy=0, no done; a new start then runs the basic sequence.
// - LOAD_LAT=3: basic stimulus.
//   -> FEED0 starts at cycle 5; captured values match the UB contents at cycle 1+LOAD_LAT.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU definitions: datapath widths, unified-buffer geometry and the
// state set of the unified-buffer input feeder.
package tpu_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 13;
    localparam int UB_DEPTH = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        FEED0 = 3'd3,
        FEED1 = 3'd4,
        FEED2 = 3'd5,
        DONE  = 3'd6
    } feeder_state_t;

    // True in the three cycles where lane beats are presented to the array.
    function automatic logic is_feed(input feeder_state_t s);
        return (s == FEED0) || (s == FEED1) || (s == FEED2);
    endfunction

endpackage

// File: rtl/skew_lane_reg.sv
// One-stage data+valid register used to delay a lane by one beat.
// When en is low the stored beat is held, so a stalled array never loses
// or sees a repeated beat.
module skew_lane_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    input  logic         d_valid,
    output logic [W-1:0] q,
    output logic         q_valid
);

    // Load the next beat on an accepted advance, otherwise hold it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/ub_input_feeder.sv
// Fetches one 2x2 activation tile from the unified buffer and streams it
// into the left edge of the 2-row systolic array as two skewed lanes:
// row 1 gets t00,t01 and row 2 gets t10,t11 one beat later.
module ub_input_feeder
    import tpu_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              array_ready,
    output logic [ADDR_W-1:0] ub_addr,
    output logic              ub_load_input,
    input  logic [DATA_W-1:0] ub_in_00,
    input  logic [DATA_W-1:0] ub_in_01,
    input  logic [DATA_W-1:0] ub_in_10,
    input  logic [DATA_W-1:0] ub_in_11,
    output logic [DATA_W-1:0] lane1_data,
    output logic              lane1_valid,
    output logic [DATA_W-1:0] lane2_data,
    output logic              lane2_valid,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam int                WAIT_W    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_LAT - 1);
    localparam logic [ADDR_W-1:0] MAX_BASE  = ADDR_W'(UB_DEPTH - 4);

    feeder_state_t     state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              err_q;
    logic [DATA_W-1:0] t00, t01, t10, t11;
    logic              lane2_en;
    logic [DATA_W-1:0] lane2_next;
    logic              lane2_next_valid;

    // Sequencer: accept a request, issue the read, wait out the buffer
    // latency, capture the tile, then step through the three feed beats.
    // ub_addr only changes when a legal tile is requested, so it holds the
    // last issued address otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ub_addr  <= '0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            t00      <= '0;
            t01      <= '0;
            t10      <= '0;
            t11      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (base_addr > MAX_BASE) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_q   <= 1'b0;
                            ub_addr <= base_addr;
                            state   <= REQ;
                        end
                    end
                end
                REQ: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        t00      <= ub_in_00;
                        t01      <= ub_in_01;
                        t10      <= ub_in_10;
                        t11      <= ub_in_11;
                        wait_cnt <= '0;
                        state    <= FEED0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                FEED0: if (array_ready) state <= FEED1;
                FEED1: if (array_ready) state <= FEED2;
                FEED2: if (array_ready) state <= DONE;
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row-1 lane is presented directly from the current feed beat.
    always_comb begin
        lane1_data  = '0;
        lane1_valid = 1'b0;
        case (state)
            FEED0: begin
                lane1_data  = t00;
                lane1_valid = 1'b1;
            end
            FEED1: begin
                lane1_data  = t01;
                lane1_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Row-2 lane is staged one beat ahead into the skew register, which
    // advances only on accepted beats and empties itself after t11.
    always_comb begin
        lane2_en         = is_feed(state) && array_ready;
        lane2_next       = '0;
        lane2_next_valid = 1'b0;
        if (state == FEED0) begin
            lane2_next       = t10;
            lane2_next_valid = 1'b1;
        end else if (state == FEED1) begin
            lane2_next       = t11;
            lane2_next_valid = 1'b1;
        end
    end

    skew_lane_reg #(
        .W (DATA_W)
    ) u_lane2 (
        .clk     (clk),
        .reset   (reset),
        .en      (lane2_en),
        .d       (lane2_next),
        .d_valid (lane2_next_valid),
        .q       (lane2_data),
        .q_valid (lane2_valid)
    );

    assign ub_load_input = (state == REQ);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign addr_err      = (state == DONE) && err_q;

endmodule
